// File: rtl/synth_voice_pkg.sv
// Shared types and defaults for the synth voice allocator.
// Event record, FSM states and slot-count defaults.
package synth_voice_pkg;
  localparam int VOICES_DEF  = 8;
  localparam int V_WIDTH_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    ISSUE,
    HOLD,
    GAP
  } state_t;

  typedef struct packed {
    logic       on;
    logic [7:0] key;
    logic [7:0] vel;
  } event_t;
endpackage

// File: rtl/voice_lru.sv
// Least-recently-allocated ranking of voice slots.
// Rank 0 is newest; rank VOICES-1 is the steal candidate.
module voice_lru
  import synth_voice_pkg::*;
#(
  parameter int VOICES  = VOICES_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch,
  input  logic [V_WIDTH-1:0] touch_adr,
  output logic [V_WIDTH-1:0] oldest
);

  logic [V_WIDTH-1:0] rank [VOICES];
  logic [V_WIDTH-1:0] old_rank;

  assign old_rank = rank[touch_adr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++)
        rank[v] <= V_WIDTH'(v);
    end else if (touch) begin
      for (int v = 0; v < VOICES; v++) begin
        if (V_WIDTH'(v) == touch_adr)
          rank[v] <= '0;
        else if (rank[v] < old_rank)
          rank[v] <= rank[v] + 1'b1;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int v = 0; v < VOICES; v++)
      if (rank[v] == V_WIDTH'(VOICES - 1))
        oldest = V_WIDTH'(v);
  end

endmodule

// File: rtl/voice_allocator.sv
// Note event to voice slot scheduler with oldest-voice stealing.
// Outputs are held across a frame boundary for the sweep sampler.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int VOICES  = VOICES_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF
) (
  input  logic               OSC_CLK,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [7:0]         ev_key,
  input  logic [7:0]         ev_vel,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [VOICES-1:0]  keys_on,
  output logic               stolen
);

  state_t             state, nxt;
  event_t             ev_q;
  logic [V_WIDTH-1:0] idx;
  logic               match_hit, free_hit, drop;
  logic [V_WIDTH-1:0] match_adr, free_adr;
  logic [7:0]         key_mem [VOICES];

  logic               last, accept, issue_now;
  logic               fin_match_hit, fin_free_hit;
  logic [V_WIDTH-1:0] fin_match_adr, fin_free_adr;
  logic [V_WIDTH-1:0] target, oldest;
  logic               steal, do_on, do_off;

  assign last   = idx == V_WIDTH'(VOICES - 1);
  assign accept = (state == IDLE) && ev_valid && ev_ready;

  // Fold the voice under the scan pointer into the running results
  always_comb begin
    fin_match_hit = match_hit;
    fin_match_adr = match_adr;
    fin_free_hit  = free_hit;
    fin_free_adr  = free_adr;
    if (!match_hit && keys_on[idx] && key_mem[idx] == ev_q.key) begin
      fin_match_hit = 1'b1;
      fin_match_adr = idx;
    end
    if (!free_hit && !keys_on[idx]) begin
      fin_free_hit = 1'b1;
      fin_free_adr = idx;
    end
  end

  always_comb begin
    target = oldest;
    steal  = 1'b0;
    if (fin_match_hit)
      target = fin_match_adr;
    else if (fin_free_hit)
      target = fin_free_adr;
    else
      steal = 1'b1;
  end

  assign issue_now = (state == SEARCH) && last;
  assign do_on     = issue_now && ev_q.on;
  assign do_off    = issue_now && !ev_q.on && fin_match_hit;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = SEARCH;
      SEARCH:  if (last) nxt = ISSUE;
      ISSUE:   nxt = drop ? IDLE : HOLD;
      HOLD:    if (frame_tick) nxt = GAP;
      GAP:     if (frame_tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge OSC_CLK) begin
    if (reset) begin
      state       <= IDLE;
      ev_ready    <= 1'b0;
      ev_q        <= '0;
      idx         <= '0;
      match_hit   <= 1'b0;
      match_adr   <= '0;
      free_hit    <= 1'b0;
      free_adr    <= '0;
      drop        <= 1'b0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      keys_on     <= '0;
      stolen      <= 1'b0;
      for (int v = 0; v < VOICES; v++)
        key_mem[v] <= '0;
    end else begin
      state    <= nxt;
      ev_ready <= nxt == IDLE;
      stolen   <= 1'b0;
      if (accept) begin
        ev_q.on   <= ev_on && (ev_vel != 8'd0);
        ev_q.key  <= ev_key;
        ev_q.vel  <= ev_vel;
        idx       <= '0;
        match_hit <= 1'b0;
        free_hit  <= 1'b0;
      end
      if (state == SEARCH) begin
        idx       <= idx + 1'b1;
        match_hit <= fin_match_hit;
        match_adr <= fin_match_adr;
        free_hit  <= fin_free_hit;
        free_adr  <= fin_free_adr;
      end
      if (issue_now)
        drop <= !ev_q.on && !fin_match_hit;
      if (do_on) begin
        keys_on[target] <= 1'b1;
        key_mem[target] <= ev_q.key;
        cur_key_adr     <= target;
        cur_key_val     <= ev_q.key;
        cur_vel_on      <= ev_q.vel;
        note_on         <= 1'b1;
        stolen          <= steal;
      end
      if (do_off) begin
        keys_on[fin_match_adr] <= 1'b0;
        cur_key_adr            <= fin_match_adr;
        note_on                <= 1'b0;
      end
      if (state == HOLD && frame_tick)
        note_on <= 1'b0;
    end
  end

  voice_lru #(
    .VOICES (VOICES),
    .V_WIDTH(V_WIDTH)
  ) u_lru (
    .clk      (OSC_CLK),
    .reset    (reset),
    .touch    (do_on),
    .touch_adr(target),
    .oldest   (oldest)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed note events,
// monitor pops expected output records on every output change.
module tb_voice_allocator;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] val;
    logic [7:0] vel;
    logic [7:0] keys;
    logic       note;
    logic       stl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic       ev_on = 1'b0;
  logic [7:0] ev_key = '0;
  logic [7:0] ev_vel = '0;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val;
  logic [7:0] cur_vel_on;
  logic [7:0] keys_on;
  logic       stolen;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  voice_allocator #(.VOICES(8), .V_WIDTH(3)) dut (
    .OSC_CLK    (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_key     (ev_key),
    .ev_vel     (ev_vel),
    .note_on    (note_on),
    .cur_key_adr(cur_key_adr),
    .cur_key_val(cur_key_val),
    .cur_vel_on (cur_vel_on),
    .keys_on    (keys_on),
    .stolen     (stolen)
  );

  // Monitor: any new output record must match the head of the queue
  logic rst_d = 1'b1;
  exp_t act, prev = '0, e_pop;
  logic chg;

  always @(posedge clk) rst_d <= reset;

  always @(negedge clk) begin
    act = {cur_key_adr, cur_key_val, cur_vel_on, keys_on, note_on, stolen};
    chg = stolen || (note_on && !prev.note) || keys_on != prev.keys ||
          cur_key_adr != prev.adr || cur_key_val != prev.val ||
          cur_vel_on != prev.vel;
    if (!rst_d && chg) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", act);
      end else begin
        e_pop = q.pop_front();
        if (act !== e_pop) begin
          bad++;
          $display("FAIL output_record actual=%h required=%h", act, e_pop);
        end
      end
    end
    prev = act;
  end

  task automatic chk(input string name, input int a, input int r);
    total++;
    if (a != r) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  function automatic exp_t mk(input int adr, input int val, input int vel,
                              input int keys, input int note, input int stl);
    exp_t e;
    e.adr  = 3'(adr);
    e.val  = 8'(val);
    e.vel  = 8'(vel);
    e.keys = 8'(keys);
    e.note = 1'(note);
    e.stl  = 1'(stl);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", int'({note_on, cur_key_adr, cur_key_val,
                               cur_vel_on, keys_on, stolen}), 0);
    chk("reset_ready", int'(ev_ready), 0);
  endtask

  // mode 0: normal issue, 1: dropped note-off, 2: reset while holding
  task automatic do_event(input bit on, input int key, input int vel,
                          input int mode, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = 8'(key);
    ev_vel   = 8'(vel);
    if (mode != 1) q.push_back(e);
    @(negedge clk);
    ev_valid = 1'b0;
    chk("ready_drop", int'(ev_ready), 0);
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    chk("ready_in_issue", int'(ev_ready), 0);
    if (mode == 1) begin
      @(negedge clk);
      chk("drop_ready_back", int'(ev_ready), 1);
      return;
    end
    @(negedge clk);
    chk("stolen_pulse", int'(stolen), 0);
    if (mode == 2) begin
      chk("note_before_reset", int'(note_on), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_hold_out", int'({note_on, cur_key_adr, cur_key_val,
                                  cur_vel_on, keys_on, stolen}), 0);
      return;
    end
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    chk("note_hold", int'(note_on), int'(e.note));
    @(negedge clk);
    frame_tick = 1'b0;
    chk("note_fall", int'(note_on), 0);
    chk("ready_in_gap", int'(ev_ready), 0);
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("ready_back", int'(ev_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", int'({note_on, cur_key_adr, cur_key_val,
                               cur_vel_on, keys_on, stolen}), 0);
    chk("reset_ready", int'(ev_ready), 0);

    do_event(1, 60, 100, 0, mk(0, 60, 100, 8'h01, 1, 0));
    do_event(0, 60, 0,   0, mk(0, 60, 100, 8'h00, 0, 0));
    do_event(1, 60, 70,  0, mk(0, 60, 70,  8'h01, 1, 0));
    do_event(1, 60, 0,   0, mk(0, 60, 70,  8'h00, 0, 0));
    do_event(0, 99, 0,   1, mk(0, 0, 0, 0, 0, 0));
    do_event(1, 60, 100, 0, mk(0, 60, 100, 8'h01, 1, 0));
    do_event(1, 60, 50,  0, mk(0, 60, 50,  8'h01, 1, 0));

    do_reset();
    for (int i = 0; i < 8; i++)
      do_event(1, 40 + i, 10 + i, 0,
               mk(i, 40 + i, 10 + i, (1 << (i + 1)) - 1, 1, 0));
    do_event(1, 80, 90, 0, mk(0, 80, 90, 8'hFF, 1, 1));
    do_event(1, 81, 91, 0, mk(1, 81, 91, 8'hFF, 1, 1));
    do_event(0, 41, 0,  1, mk(0, 0, 0, 0, 0, 0));
    do_event(0, 47, 0,  0, mk(7, 81, 91, 8'h7F, 0, 0));
    do_event(1, 30, 33, 2, mk(7, 30, 33, 8'hFF, 1, 0));
    do_event(1, 20, 22, 0, mk(0, 20, 22, 8'h01, 1, 0));

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Event-to-voice scheduler for the synth engine. It accepts note-on and note-off events and assigns each to one of `VOICES` voice slots. When no slot is free, it steals the least-recently-allocated voice. It drives the note/key/velocity/keys-on bus that the voice sweep samples at each frame boundary, and holds every event stable across that boundary so the sweep-side sampler captures it exactly once.

## Interface
Parameters:
- `VOICES`, 8: number of voice slots; power of two.
- `V_WIDTH`, 3: log2(`VOICES`); width of the voice address.

Ports:
- `OSC_CLK`, in, 1: the only clock; all logic is on the rising edge.
- `reset`, in, 1: one clock; reset is synchronous and active-high.
- `frame_tick`, in, 1: one-cycle pulse in the `OSC_CLK` domain at each voice-sweep zero (frame boundary).
- `ev_valid`, in, 1: an event is presented.
- `ev_ready`, out, 1: the allocator accepts an event this cycle.
- `ev_on`, in, 1: 1 = note-on, 0 = note-off.
- `ev_key`, in, 8: key number.
- `ev_vel`, in, 8: velocity.
- `note_on`, out, 1: trigger request for `cur_key_adr`.
- `cur_key_adr`, out, `V_WIDTH`: voice index of the current event.
- `cur_key_val`, out, 8: key assigned to that voice.
- `cur_vel_on`, out, 8: note-on velocity of that voice.
- `keys_on`, out, `VOICES`: bit v = voice v is held.
- `stolen`, out, 1: one-cycle pulse when an allocation steals a held voice.

## Operation
- Reset values: all outputs 0; `ev_ready` = 0; all voice key registers 0; LRU rank of voice v = v (voice `VOICES-1` is oldest); state IDLE.
- FSM states: IDLE, SEARCH, ISSUE, HOLD, GAP.
- IDLE: `ev_ready` = 1. When `ev_valid` & `ev_ready`, latch the event and go to SEARCH.
- Event classification: note-on with `ev_vel` = 0 is a note-off.
- SEARCH scans v = 0..`VOICES-1`, one voice per cycle. It records:
  - match = first held voice whose stored key equals `ev_key`;
  - free = lowest-index voice with `keys_on[v]` = 0.
- After the scan, go to ISSUE.
- ISSUE, note-on:
  - Target voice: match, else free, else the voice with LRU rank `VOICES-1`. `stolen` pulses only in the steal case.
  - Update: set `keys_on[target]`, store the key, set `cur_key_adr`/`cur_key_val`/`cur_vel_on`, set `note_on` = 1.
  - LRU: target rank becomes 0; every voice with rank lower than the target's old rank increments by 1. Ranks remain a permutation.
- ISSUE, note-off:
  - With a match: clear `keys_on[match]`, set `cur_key_adr` = match, `note_on` = 0. `cur_key_val` and `cur_vel_on` are unchanged. LRU is unchanged.
  - Without a match: the event is dropped and the FSM returns directly to IDLE with no output change.
- HOLD: all outputs are frozen until `frame_tick`. On that cycle, `note_on` drops to 0 and the FSM goes to GAP.
- GAP: wait for the next `frame_tick`, then go to IDLE.
- `frame_tick` in IDLE, SEARCH or ISSUE is ignored.
- `reset` in any state aborts the event in flight and restores reset values on the next edge.

## Timing
- Accept edge t: `ev_ready` drops at t+1.
- SEARCH occupies t+1 .. t+`VOICES`.
- Outputs update at t+`VOICES`+1 (ISSUE); `stolen` is high in that cycle only.
- `note_on` stays high through the cycle carrying the first `frame_tick` after ISSUE and falls the edge after it.
- `ev_ready` returns 1 the cycle after the second `frame_tick`.
- Minimum event spacing: `VOICES`+2 cycles plus two frame periods.
- Dropped note-off: `ev_ready` returns 1 at t+`VOICES`+2.

## Structure
- Package `synth_voice_pkg`: FSM state enum, the `VOICES`/`V_WIDTH` defaults, and the event record (on, key, vel).
- Sub-module `voice_lru`: holds `VOICES` ranks of `V_WIDTH` bits each. It has a touch port (touch strobe + voice index) and an oldest-voice output. It resets to rank v = v.
- Top level holds the FSM, scan counter, key register array and output registers.

## Test plan
- Single note: after reset, note-on key 60 vel 100.
  - Expect `cur_key_adr` = 0, `cur_key_val` = 60, `cur_vel_on` = 100, `keys_on` = 0x01, `note_on` = 1 from t+9.
  - `note_on` falls after the first `frame_tick`; `ev_ready` = 1 after the second.
- Note-off: note-on 60 then note-off 60 → `keys_on` = 0x00, `cur_key_adr` = 0, `note_on` stays 0.
- Velocity-zero off and unknown key: note-on 60 vel 0 behaves as note-off. Note-off for key 99 (not held) → no output change; `ev_ready` returns 1 at t+10.
- Retrigger: hold 60 on voice 0, send note-on 60 vel 50 → `cur_key_adr` = 0, `cur_vel_on` = 50, `keys_on` unchanged, `stolen` = 0.
- Steal: fill voices 0..7 with keys 40..47, then note-on key 80.
  - Expect target voice 0 (oldest), `stolen` pulse, `cur_key_val` = 80, `keys_on` = 0xFF.
  - A further note-on key 81 steals voice 1.
- Reset in HOLD: assert `reset` while `note_on` = 1 → next cycle all outputs 0 and `keys_on` = 0. After reset, the next note-on takes voice 0.
